// File: rtl/reg_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_bus_pkg
//  Description : Register-bank write-bus definitions shared by the write
//                arbiter and its rotating priority encoder: bus widths,
//                grant index width and the sequencer state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package reg_bus_pkg;

  localparam int REG_ADDR_WIDTH = 8;
  localparam int REG_DATA_WIDTH = 32;
  localparam int GRANT_ID_WIDTH = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

endpackage : reg_bus_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Purely combinational rotating priority encoder. The search
//                starts one position after last_grant and wraps modulo
//                NUM_REQ; the first set request wins.
//  Ports       : req        in  NUM_REQ         request vector
//                last_grant in  GRANT_ID_WIDTH  index of the previous winner
//                grant      out NUM_REQ         one-hot grant (0 if no request)
//                grant_idx  out GRANT_ID_WIDTH  encoded index of the winner
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import reg_bus_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]        req,
  input  logic [GRANT_ID_WIDTH-1:0] last_grant,
  output logic [NUM_REQ-1:0]        grant,
  output logic [GRANT_ID_WIDTH-1:0] grant_idx
);

  logic                found;
  logic [NUM_REQ-1:0]  rot;
  int                  cand;

  // Shifts are used instead of variable bit-selects so the index width never
  // has to match the vector width.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    rot       = '0;
    cand      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_grant) + k) % NUM_REQ;
      rot  = req >> cand;
      if (!found && rot[0]) begin
        found     = 1'b1;
        grant     = NUM_REQ'(1) << cand;
        grant_idx = GRANT_ID_WIDTH'(cand);
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : reg_write_arbiter
//  Description : Round-robin arbiter/sequencer for the shared register-bank
//                write bus. One requester is accepted per cycle; its pair is
//                registered and issued as a one-cycle write strobe on the
//                following cycle. Optional burst locking is compiled in with
//                the macro REG_WRITE_ARB_LOCK_EN.
//  Ports       : clk, rst      clock, synchronous active-high reset
//                req_valid     in  NUM_REQ      pending-write flags
//                req_addr      in  NUM_REQ*8    packed addresses
//                req_data      in  NUM_REQ*32   packed data
//                req_lock      in  NUM_REQ      burst lock request
//                req_ready     out NUM_REQ      one-hot acceptance
//                reg_write_en  out 1            write strobe
//                reg_addr      out 8            registered address
//                reg_data      out 32           registered data
//                grant_id      out 3            owner of current strobe
//                busy          out 1            write issuing or lock held
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_write_arbiter
  import reg_bus_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int MAX_BURST = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ*REG_ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*REG_DATA_WIDTH-1:0]  req_data,
  input  logic [NUM_REQ-1:0]                 req_lock,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic                               reg_write_en,
  output logic [REG_ADDR_WIDTH-1:0]          reg_addr,
  output logic [REG_DATA_WIDTH-1:0]          reg_data,
  output logic [GRANT_ID_WIDTH-1:0]          grant_id,
  output logic                               busy
);

  localparam logic [3:0]                BURST_MAX  = 4'(MAX_BURST);
  localparam logic [GRANT_ID_WIDTH-1:0] LAST_RESET = GRANT_ID_WIDTH'(NUM_REQ - 1);

  state_t                      state, state_next;
  logic [GRANT_ID_WIDTH-1:0]   last_grant;
  logic [GRANT_ID_WIDTH-1:0]   rr_idx, win_idx;
  logic [NUM_REQ-1:0]          rr_gnt, grant;
  logic                        accept;
  logic [REG_ADDR_WIDTH-1:0]   sel_addr;
  logic [REG_DATA_WIDTH-1:0]   sel_data;

  rr_arbiter #(
    .NUM_REQ    (NUM_REQ)
  ) u_rr_arbiter (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (rr_gnt),
    .grant_idx  (rr_idx)
  );

`ifdef REG_WRITE_ARB_LOCK_EN
  logic [3:0]          burst_cnt, burst_next, burst_inc;
  logic [NUM_REQ-1:0]  owner_oh;
  logic                lock_win;

  // While locked, grant_id still names the owner: only the owner can be
  // accepted, so the register never changes during a burst. A cycle with the
  // owner invalid yields no acceptance, which drops the FSM back to IDLE and
  // lets round-robin resume from owner+1 on the next cycle.
  always_comb begin
    owner_oh   = NUM_REQ'(1) << grant_id;
    grant      = rr_gnt;
    win_idx    = rr_idx;
    if (state == ST_LOCKED) begin
      grant   = req_valid & owner_oh;
      win_idx = grant_id;
    end
    accept     = |grant;
    lock_win   = |(grant & req_lock);
    burst_inc  = ((state == ST_LOCKED) ? burst_cnt : 4'd0) + 4'd1;
    burst_next = 4'd0;
    state_next = ST_IDLE;
    if (accept) begin
      if (lock_win && (burst_inc < BURST_MAX)) begin
        state_next = ST_LOCKED;
        burst_next = burst_inc;
      end else begin
        state_next = ST_WRITE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      burst_cnt <= 4'd0;
    end else begin
      burst_cnt <= burst_next;
    end
  end
`else
  always_comb begin
    grant      = rr_gnt;
    win_idx    = rr_idx;
    accept     = |grant;
    state_next = accept ? ST_WRITE : ST_IDLE;
  end

  logic unused_lock;
  assign unused_lock = ^{req_lock, BURST_MAX};
`endif

  // The grant is one-hot, so at most one slot is selected.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
        sel_data = req_data[i*REG_DATA_WIDTH +: REG_DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      last_grant   <= LAST_RESET;
      reg_write_en <= 1'b0;
      reg_addr     <= '0;
      reg_data     <= '0;
      grant_id     <= '0;
    end else begin
      state        <= state_next;
      reg_write_en <= accept;
      if (accept) begin
        last_grant <= win_idx;
        grant_id   <= win_idx;
        reg_addr   <= sel_addr;
        reg_data   <= sel_data;
      end
    end
  end

  assign req_ready = grant;
  assign busy      = reg_write_en | (state == ST_LOCKED);

endmodule : reg_write_arbiter
`default_nettype wire
